primus_imem_responder: RTL and testbench

//  Instruction-memory responder: the memory-side end of the fetch interface driven by primus_instruction_fetch.

---
 rtl/primus_pkg.sv | 13 +
 rtl/primus_sync_fifo.sv | 57 +++++
 rtl/primus_imem_responder.sv | 149 ++++++++++++++
 tb/tb_primus_imem_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/primus_pkg.sv
// Shared types and constants for the primus instruction-memory path.
package primus_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] IMEM_ERR_DATA = 32'h0;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } imem_rsp_t;

endpackage

// File: rtl/primus_sync_fifo.sv
// Synchronous FIFO with a type parameter; the head is presented combinationally and reads as zero when empty.
module primus_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : store[rd_ptr];

  // NOTE: storage arrays carry no reset; only pointers and counts do, so the array maps onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (push_ok) store[wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/primus_imem_responder.sv
// Memory-side end of the instruction-fetch interface: word ROM/RAM, fixed-latency read pipeline, in-order response FIFO.
// Optional PRIMUS_IMEM_ALIGN_CHECK_EN faults misaligned fetches; contents are loaded through the program-load port.
module primus_imem_responder
  import primus_pkg::*;
#(
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [XLEN-1:0] addr_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  input  logic            rready_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  input  logic            we_i,
  input  logic [XLEN-1:0] waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [CW-1:0]   outstanding;
  logic [AW-1:0]   ridx;
  logic [AW-1:0]   widx;
  logic            range_err;
  logic            fetch_err;
  logic            wr_ok;
  logic            pop;
  logic            push_valid;
  imem_rsp_t       push_rsp;
  imem_rsp_t       head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            unused_bits;

  assign ridx      = addr_i[AW+1:2];
  assign widx      = waddr_i[AW+1:2];
  assign range_err = addr_i[XLEN-1:2] >= (XLEN-2)'(DEPTH);
  assign wr_ok     = we_i && (waddr_i[XLEN-1:2] < (XLEN-2)'(DEPTH));

`ifdef PRIMUS_IMEM_ALIGN_CHECK_EN
  assign fetch_err = range_err || (addr_i[1:0] != 2'b00);
`else
  assign fetch_err = range_err;
`endif

  // The counter bounds pipeline plus FIFO occupancy, so the FIFO can never be full on a push.
  assign unused_bits = ^{waddr_i[1:0], addr_i[1:0], fifo_full};

  // Grant looks only at registered state, never at this cycle's pop.
  assign gnt_o    = rst_ni && req_i && (outstanding < CW'(MAX_OUTSTANDING));
  assign rvalid_o = !fifo_empty;
  assign pop      = rvalid_o && rready_i;
  assign rdata_o  = head.rdata;
  assign err_o    = head.err;

  // NOTE: non-blocking write means a read of the same word in the same cycle sees the old contents.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[widx] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({gnt_o, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      // Single-cycle latency: the grant edge itself pushes the response.
      assign push_valid = gnt_o;
      assign push_rsp   = '{rdata: fetch_err ? IMEM_ERR_DATA : mem[ridx], err: fetch_err};
    end else begin : g_pipe
      logic            rd_vld;
      logic            rd_err;
      logic [XLEN-1:0] rd_data;
      imem_rsp_t       rd_rsp;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_vld <= 1'b0;
          rd_err <= 1'b0;
        end else begin
          rd_vld <= gnt_o;
          if (gnt_o) rd_err <= fetch_err;
        end
      end

      always_ff @(posedge clk_i) begin
        if (gnt_o && !range_err) rd_data <= mem[ridx];
      end

      assign rd_rsp = '{rdata: rd_err ? IMEM_ERR_DATA : rd_data, err: rd_err};

      if (LATENCY == 2) begin : g_direct
        assign push_valid = rd_vld;
        assign push_rsp   = rd_rsp;
      end else begin : g_delay
        localparam int ND = LATENCY - 2;
        logic [ND-1:0] dly_vld;
        imem_rsp_t     dly_rsp [ND];

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            dly_vld <= '0;
          end else begin
            dly_vld[0] <= rd_vld;
            for (int i = 1; i < ND; i++) dly_vld[i] <= dly_vld[i-1];
          end
        end

        always_ff @(posedge clk_i) begin
          dly_rsp[0] <= rd_rsp;
          for (int i = 1; i < ND; i++) dly_rsp[i] <= dly_rsp[i-1];
        end

        assign push_valid = dly_vld[ND-1];
        assign push_rsp   = dly_rsp[ND-1];
      end
    end
  endgenerate

  primus_sync_fifo #(
    .T     (imem_rsp_t),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_valid),
    .wdata_i (push_rsp),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_primus_imem_responder.sv
// Scoreboard bench for primus_imem_responder: expected responses queued at grant, compared by a negedge monitor.
module tb_primus_imem_responder;

  localparam int DEPTH   = 16;
  localparam int LAT     = 2;
  localparam int MAX_OUT = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [31:0] addr_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        we_i;
  logic [31:0] waddr_i;
  logic [31:0] wdata_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cycle   = 0;
  int          outstanding = 0;
  exp_t        q[$];
  logic [31:0] model_mem [DEPTH];

  primus_imem_responder #(
    .DEPTH           (DEPTH),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .we_i     (we_i),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, got, exp);
    end
  endtask

  // Expected response from the address rules and the bench's own copy of memory.
  function automatic exp_t model(input logic [31:0] a, input int cyc);
    exp_t e;
    e.cyc = cyc;
    if (a[31:2] >= 30'(DEPTH)) begin
      e.data = 32'h0;
      e.err  = 1'b1;
    end
`ifdef PRIMUS_IMEM_ALIGN_CHECK_EN
    else if (a[1:0] != 2'b00) begin
      e.data = 32'h0;
      e.err  = 1'b1;
    end
`endif
    else begin
      e.data = model_mem[int'(a[31:2])];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // Monitor: grant check, response check against queue head, then model update.
  always @(negedge clk) begin
    logic exp_gnt;
    exp_t e;
    if (!rst_ni) begin
      q.delete();
      outstanding = 0;
      check("rst_gnt", {31'b0, gnt_o}, 32'd0);
      check("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
    end else begin
      exp_gnt = req_i && (outstanding < MAX_OUT);
      check("gnt", {31'b0, gnt_o}, {31'b0, exp_gnt});
      if (rvalid_o) begin
        if (q.size() == 0) begin
          check("spurious_rvalid", {31'b0, rvalid_o}, 32'd0);
        end else begin
          e = q[0];
          check("rdata", rdata_o, e.data);
          check("err", {31'b0, err_o}, {31'b0, e.err});
          check("latency_min", {31'b0, (cycle - e.cyc) >= LAT}, 32'd1);
          if (rready_i) begin
            void'(q.pop_front());
            if (outstanding > 0) outstanding--;
          end
        end
      end
      if (req_i && gnt_o) begin
        q.push_back(model(addr_i, cycle));
        outstanding++;
      end
      if (we_i && (waddr_i[31:2] < 30'(DEPTH))) model_mem[int'(waddr_i[31:2])] = wdata_i;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_i    = 1'b0;
    we_i     = 1'b0;
    rready_i = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cyc();
    cyc();
    check("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    int word;
    logic [1:0] lo;
    rst_ni   = 1'b0;
    req_i    = 1'b1;
    addr_i   = 32'h0;
    rready_i = 1'b1;
    we_i     = 1'b0;
    waddr_i  = 32'h0;
    wdata_i  = 32'h0;

    // Reset held with a pending request, then released mid-cycle.
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    #1;
    check("gnt_after_release", {31'b0, gnt_o}, 32'd1);
    req_i = 1'b0;
    cyc();
    drain();

    // Program load, plus an out-of-range write that must not alias onto word 0.
    for (int i = 0; i < DEPTH; i++) begin
      we_i    = 1'b1;
      waddr_i = 32'(i * 4);
      wdata_i = 32'hA000_0000 + 32'(i);
      cyc();
    end
    waddr_i = 32'h40;
    wdata_i = 32'h1234_5678;
    cyc();
    we_i = 1'b0;
    cyc();

    // Single fetch: visible exactly two cycles after the grant.
    req_i  = 1'b1;
    addr_i = 32'h8;
    @(negedge clk);
    check("single_gnt", {31'b0, gnt_o}, 32'd1);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    @(negedge clk);
    check("single_t1_rvalid", {31'b0, rvalid_o}, 32'd0);
    @(negedge clk);
    check("single_t2_rvalid", {31'b0, rvalid_o}, 32'd1);
    check("single_t2_rdata", rdata_o, 32'hA000_0002);
    drain();

    // Back-to-back stream: all eight responses consumed on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      req_i  = 1'b1;
      addr_i = 32'(i * 4);
      cyc();
    end
    req_i = 1'b0;
    @(negedge clk);
    check("stream_t8_rvalid", {31'b0, rvalid_o}, 32'd1);
    @(negedge clk);
    check("stream_t9_rvalid", {31'b0, rvalid_o}, 32'd1);
    #1;
    check("stream_all_popped", q.size(), 32'd0);
    cyc();
    drain();

    // Backpressure: four grants, head held stable, then release.
    rready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_i  = 1'b1;
      addr_i = 32'(i * 4);
      cyc();
    end
    check("bp_queue_depth", q.size(), 32'(MAX_OUT));
    rready_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    drain();

    // Fault responses: out of range and misaligned.
    req_i  = 1'b1;
    addr_i = 32'h40;
    cyc();
    addr_i = 32'h6;
    cyc();
    drain();

    // Write and fetch of the same word in one cycle, then a fresh fetch.
    we_i    = 1'b1;
    waddr_i = 32'hC;
    wdata_i = 32'hDEAD_BEEF;
    req_i   = 1'b1;
    addr_i  = 32'hC;
    cyc();
    we_i = 1'b0;
    cyc();
    drain();

    // Reset with three responses in flight.
    rready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_i  = 1'b1;
      addr_i = 32'(i * 4);
      cyc();
    end
    req_i = 1'b0;
    cyc();
    check("pre_reset_rvalid", {31'b0, rvalid_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("reset_async_rvalid", {31'b0, rvalid_o}, 32'd0);
    rready_i = 1'b1;
    cyc();
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    drain();

    // Randomized traffic with writes and backpressure.
    for (int i = 0; i < 400; i++) begin
      word     = $urandom_range(0, 19);
      lo       = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      req_i    = ($urandom_range(0, 3) != 0);
      addr_i   = 32'(word * 4) | {30'b0, lo};
      rready_i = ($urandom_range(0, 3) != 0);
      we_i     = ($urandom_range(0, 5) == 0);
      waddr_i  = 32'($urandom_range(0, 19) * 4);
      wdata_i  = $urandom;
      cyc();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
